// File: rtl/btn_debounce_pkg.sv
// btn_debounce_pkg: default sizing for the button debouncer and a width check helper.
package btn_debounce_pkg;
   localparam int DEF_N_BTN        = 2;
   localparam int DEF_TICK_DIV     = 8000;
   localparam int DEF_TICK_W       = 13;
   localparam int DEF_STABLE_TICKS = 4;
   localparam int DEF_STB_W        = 3;
   function automatic bit fits(input int w, input int v);
      return (longint'(1) << w) >= longint'(v);
   endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel; synchronizer, tick qualifier, stable level and event flops.
// Toggle flops exist only when BTN_DEBOUNCE_TOGGLE_EN is defined.
module btn_debounce_ch
   import btn_debounce_pkg::*;
#(
   parameter int STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int STB_W        = DEF_STB_W
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic btn_raw,
   input  logic tick,
   output logic stable,
   output logic press,
   output logic rel,
   output logic toggle
);
   logic [1:0]       sync_q, sync_d;
   logic [STB_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d, press_q, press_d, rel_q, rel_d;
   logic             btn_s, chg, hit;
   always_comb begin
      sync_d   = {sync_q[0], btn_raw};
      btn_s    = sync_q[1];
      chg      = btn_s != stable_q;
      hit      = tick && cnt_q == STB_W'(STABLE_TICKS - 1);
      cnt_d    = (!chg || hit) ? '0 : cnt_q + STB_W'(tick);
      stable_d = (chg && hit) ? btn_s : stable_q;
      press_d  = chg && hit && btn_s;
      rel_d    = chg && hit && !btn_s;
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
         rel_q    <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         press_q  <= press_d;
         rel_q    <= rel_d;
      end
   end
   assign stable = stable_q;
   assign press  = press_q;
   assign rel    = rel_q;
`ifdef BTN_DEBOUNCE_TOGGLE_EN
   logic toggle_q, toggle_d;
   always_comb toggle_d = toggle_q ^ press_d;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) toggle_q <= 1'b0;
      else        toggle_q <= toggle_d;
   end
   assign toggle = toggle_q;
`else
   assign toggle = 1'b0;
`endif
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: shared sample-tick prescaler feeding N_BTN debounce channels.
// Define BTN_DEBOUNCE_TOGGLE_EN to build per-button press-toggle state on BTN_TOGGLE.
module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter int N_BTN        = DEF_N_BTN,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int TICK_W       = DEF_TICK_W,
   parameter int STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int STB_W        = DEF_STB_W
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [N_BTN-1:0] BTN,
   output logic [N_BTN-1:0] BTN_STABLE,
   output logic [N_BTN-1:0] BTN_PRESS,
   output logic [N_BTN-1:0] BTN_RELEASE,
   output logic [N_BTN-1:0] BTN_TOGGLE
);
   logic [TICK_W-1:0] pre_q, pre_d;
   logic              tick;
   if (TICK_DIV < 2 || STABLE_TICKS < 1 || !fits(TICK_W, TICK_DIV) || !fits(STB_W, STABLE_TICKS)) begin : g_bad_cfg
      $error("btn_debounce: illegal TICK_DIV/TICK_W/STABLE_TICKS/STB_W combination");
   end
   always_comb begin
      tick  = pre_q == TICK_W'(TICK_DIV - 1);
      pre_d = tick ? '0 : pre_q + 1'b1;
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) pre_q <= '0;
      else        pre_q <= pre_d;
   end
   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .STABLE_TICKS(STABLE_TICKS),
         .STB_W       (STB_W)
      ) u_ch (
         .CLK    (CLK),
         .RST_N  (RST_N),
         .btn_raw(BTN[i]),
         .tick   (tick),
         .stable (BTN_STABLE[i]),
         .press  (BTN_PRESS[i]),
         .rel    (BTN_RELEASE[i]),
         .toggle (BTN_TOGGLE[i])
      );
   end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed checks of btn_debounce with TICK_DIV=4, STABLE_TICKS=3.
// Toggle expectations follow BTN_DEBOUNCE_TOGGLE_EN.
module tb_btn_debounce;
   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [1:0] BTN = 2'b00;
   logic [1:0] BTN_STABLE, BTN_PRESS, BTN_RELEASE, BTN_TOGGLE;
   int         errors = 0;
   int         checks = 0;
   int         np[2];
   int         nr[2];
   int         n;

   btn_debounce #(
      .N_BTN(2), .TICK_DIV(4), .TICK_W(2), .STABLE_TICKS(3), .STB_W(2)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .BTN        (BTN),
      .BTN_STABLE (BTN_STABLE),
      .BTN_PRESS  (BTN_PRESS),
      .BTN_RELEASE(BTN_RELEASE),
      .BTN_TOGGLE (BTN_TOGGLE)
   );

   always #5 CLK = ~CLK;

   function automatic logic [1:0] tg(input logic [1:0] v);
`ifdef BTN_DEBOUNCE_TOGGLE_EN
      return v;
`else
      return 2'b00;
`endif
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      for (int i = 0; i < 2; i++) begin
         np[i] += int'(BTN_PRESS[i]);
         nr[i] += int'(BTN_RELEASE[i]);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 2; i++) begin
         np[i] = 0;
         nr[i] = 0;
      end
   endtask

   task automatic wait_for(input logic [1:0] val, output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (BTN_STABLE !== val && cyc < 40);
   endtask

   initial begin
      // scenario 1: reset holds everything low, then both buttons qualify
      BTN = 2'b11;
      repeat (3) step();
      chk("rst_stable", BTN_STABLE, 0);
      chk("rst_press", BTN_PRESS, 0);
      chk("rst_release", BTN_RELEASE, 0);
      chk("rst_toggle", BTN_TOGGLE, 0);
      clr();
      RST_N = 1'b1;
      wait_for(2'b11, n);
      chk("t1_stable", BTN_STABLE, 3);
      chk("t1_latency", n, 12);
      chk("t1_press", BTN_PRESS, 3);
      chk("t1_toggle", BTN_TOGGLE, tg(2'b11));
      step();
      chk("t1_press_end", BTN_PRESS, 0);
      chk("t1_npress0", np[0], 1);
      chk("t1_npress1", np[1], 1);
      BTN = 2'b00;
      wait_for(2'b00, n);
      chk("t1_fall", BTN_STABLE, 0);
      chk("t1_release", BTN_RELEASE, 3);
      step();
      // scenario 2: bounce on BTN[0] every 3 cycles, then hold high
      clr();
      for (int k = 0; k < 18; k++) begin
         BTN[0] = ((k / 3) % 2) == 0;
         step();
         chk("t2_bounce_stable", BTN_STABLE, 0);
      end
      BTN[0] = 1'b1;
      wait_for(2'b01, n);
      chk("t2_stable", BTN_STABLE, 1);
      chk("t2_latency_win", int'(n >= 11 && n <= 14), 1);
      chk("t2_press", BTN_PRESS, 1);
      step();
      step();
      chk("t2_npress", np[0], 1);
      chk("t2_nrelease", nr[0], 0);
      chk("t2_toggle", BTN_TOGGLE, tg(2'b10));
      // scenario 3: release of BTN[0]
      clr();
      BTN[0] = 1'b0;
      wait_for(2'b00, n);
      chk("t3_stable", BTN_STABLE, 0);
      chk("t3_latency_win", int'(n >= 11 && n <= 14), 1);
      chk("t3_release", BTN_RELEASE, 1);
      chk("t3_press", BTN_PRESS, 0);
      step();
      chk("t3_release_end", BTN_RELEASE, 0);
      chk("t3_nrelease", nr[0], 1);
      chk("t3_npress", np[0], 0);
      chk("t3_toggle", BTN_TOGGLE, tg(2'b10));
      // scenario 4: simultaneous presses, two press/release cycles
      clr();
      BTN = 2'b11;
      wait_for(2'b11, n);
      chk("t4_press_a", BTN_PRESS, 3);
      chk("t4_toggle_a", BTN_TOGGLE, tg(2'b01));
      step();
      chk("t4_press_a_end", BTN_PRESS, 0);
      BTN = 2'b00;
      wait_for(2'b00, n);
      chk("t4_release", BTN_RELEASE, 3);
      chk("t4_toggle_rel", BTN_TOGGLE, tg(2'b01));
      BTN = 2'b11;
      wait_for(2'b11, n);
      chk("t4_press_b", BTN_PRESS, 3);
      chk("t4_toggle_b", BTN_TOGGLE, tg(2'b10));
      chk("t4_npress0", np[0], 2);
      chk("t4_npress1", np[1], 2);
      step();
      // scenario 5: reset in mid-qualification, then restart from zero
      BTN = 2'b00;
      wait_for(2'b00, n);
      step();
      BTN = 2'b11;
      repeat (10) step();
      chk("t5_mid_stable", BTN_STABLE, 0);
      #2 RST_N = 1'b0;
      #1;
      chk("t5_rst_stable", BTN_STABLE, 0);
      chk("t5_rst_toggle", BTN_TOGGLE, 0);
      chk("t5_rst_press", BTN_PRESS, 0);
      step();
      RST_N = 1'b1;
      wait_for(2'b11, n);
      chk("t5_restart_latency", n, 12);
      chk("t5_press", BTN_PRESS, 3);
      chk("t5_toggle", BTN_TOGGLE, tg(2'b11));
      #2 RST_N = 1'b0;
      #1;
      chk("t5_pulse_drop", BTN_PRESS, 0);
      chk("t5_pulse_stable", BTN_STABLE, 0);
      step();
      RST_N = 1'b1;
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
